// File: rtl/fma16_issue.sv
// fma16_issue: operand issue and result-capture stage wrapped around the
// combinational fma16 datapath. Requests are queued in a small FIFO, issued
// one at a time through an IDLE/EXEC/DONE sequence, and the fma16 result is
// registered onto a valid/ready output channel.
// Optional build macro: FMA16_ISSUE_PERF_EN adds the perf_ops and perf_stall
// counters and their output ports.
module fma16_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic [15:0] in_z,
    input  logic [1:0]  in_rm,
    output logic [15:0] fma_x,
    output logic [15:0] fma_y,
    output logic [15:0] fma_z,
    output logic        fma_mul,
    output logic        fma_add,
    output logic        fma_negr,
    output logic        fma_negz,
    output logic [1:0]  fma_rm,
    input  logic [15:0] fma_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        busy
`ifdef FMA16_ISSUE_PERF_EN
    ,
    output logic [15:0] perf_ops,
    output logic [15:0] perf_stall
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [15:0] CANON_NAN = 16'h7E00;
    localparam logic [2:0]  OP_ILLEGAL = 3'b111;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [1:0]  rm;
    } entry_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // Opcode to {mul, add, negr, negz}; the illegal opcode issues all-zero controls.
    function automatic logic [3:0] decode_ctrl(input logic [2:0] op);
        logic [3:0] ctrl;
        ctrl = 4'b0000;
        case (op)
            3'b000:  ctrl = 4'b0100;
            3'b001:  ctrl = 4'b0101;
            3'b010:  ctrl = 4'b1000;
            3'b011:  ctrl = 4'b1100;
            3'b100:  ctrl = 4'b1101;
            3'b101:  ctrl = 4'b1110;
            3'b110:  ctrl = 4'b1111;
            default: ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    state_t             state;
    logic               op_ill_p0;
    entry_t             head;
    logic               push;
    logic               pop;

    assign head     = mem[rd_ptr];
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    // A new op is taken from the FIFO when idle, or when the held result is accepted.
    assign pop      = (count != '0) && ((state == IDLE) || ((state == DONE) && out_ready));
    assign busy     = (count != '0) || (state != IDLE);

    // FIFO storage: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: in_op, x: in_x, y: in_y, z: in_z, rm: in_rm};
        end
    end

    // FIFO pointers and occupancy count; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: load op register on pop, capture fma16 result after EXEC, hold in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fma_x      <= '0;
            fma_y      <= '0;
            fma_z      <= '0;
            fma_rm     <= '0;
            fma_mul    <= 1'b0;
            fma_add    <= 1'b0;
            fma_negr   <= 1'b0;
            fma_negz   <= 1'b0;
            op_ill_p0  <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
        end else begin
            if (pop) begin
                fma_x     <= head.x;
                fma_y     <= head.y;
                fma_z     <= head.z;
                fma_rm    <= head.rm;
                {fma_mul, fma_add, fma_negr, fma_negz} <= decode_ctrl(head.op);
                op_ill_p0 <= (head.op == OP_ILLEGAL);
            end
            case (state)
                IDLE: begin
                    if (pop) state <= EXEC;
                end
                EXEC: begin
                    out_result <= op_ill_p0 ? CANON_NAN : fma_result;
                    out_err    <= op_ill_p0;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= pop ? EXEC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FMA16_ISSUE_PERF_EN
    // Completed-op counter (wrapping) and input-stall counter (saturating).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready) perf_ops <= perf_ops + 16'd1;
            if (in_valid && !in_ready)  perf_stall <= sat_inc16(perf_stall);
        end
    end
`else
    // Saturating helper is only used by the optional stall counter.
    logic [15:0] sat_unused;
    assign sat_unused = sat_inc16(16'h0000);
    logic unused_ok;
    assign unused_ok = &{1'b0, sat_unused};
`endif

endmodule

// File: tb/tb_fma16_issue.sv
// Testbench for fma16_issue: directed scenarios plus randomized traffic,
// checked against a queue-based transaction model and a hashing fma16 stub.
module tb_fma16_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [15:0] in_x = '0, in_y = '0, in_z = '0;
    logic [1:0]  in_rm = '0;
    logic [15:0] fma_x, fma_y, fma_z;
    logic        fma_mul, fma_add, fma_negr, fma_negz;
    logic [1:0]  fma_rm;
    logic [15:0] fma_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_err;
    logic        busy;
`ifdef FMA16_ISSUE_PERF_EN
    logic [15:0] perf_ops, perf_stall;
`endif

    fma16_issue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_rm(in_rm),
        .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
        .fma_mul(fma_mul), .fma_add(fma_add), .fma_negr(fma_negr), .fma_negz(fma_negz),
        .fma_rm(fma_rm), .fma_result(fma_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_err(out_err), .busy(busy)
`ifdef FMA16_ISSUE_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x, y, z;
        logic [1:0]  rm;
        logic        cst;
    } txn_t;

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_hs = -1;
    logic gap_chk = 1'b0;
    logic stub_const = 1'b0;

    // Stand-in fma16: a hash of every port so wrong operands/controls show in the result.
    function automatic logic [15:0] stub_fn(input logic [15:0] x, y, z, input logic [1:0] rm,
                                            input logic [3:0] ctrl);
        return (x + {y[7:0], y[15:8]}) ^ z ^ {10'b0, rm, ctrl};
    endfunction

    always_comb begin
        fma_result = stub_const ? 16'h4200
                   : stub_fn(fma_x, fma_y, fma_z, fma_rm, {fma_mul, fma_add, fma_negr, fma_negz});
    end

    // Expected controls from the opcode table.
    function automatic logic [3:0] ref_ctrl(input logic [2:0] op);
        case (op)
            3'd0: return 4'b0100;
            3'd1: return 4'b0101;
            3'd2: return 4'b1000;
            3'd3: return 4'b1100;
            3'd4: return 4'b1101;
            3'd5: return 4'b1110;
            3'd6: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] ref_result(input txn_t t);
        if (t.op == 3'd7) return 16'h7E00;
        if (t.cst) return 16'h4200;
        return stub_fn(t.x, t.y, t.z, t.rm, ref_ctrl(t.op));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score any output handshake, record any accepted input, advance.
    task automatic step();
        txn_t t;
        logic acc;
        logic hs;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (out_valid) chk("out_has_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (hs && exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk("out_result", {16'b0, out_result}, {16'b0, ref_result(t)});
            chk("out_err", {31'b0, out_err}, {31'b0, t.op == 3'd7});
            chk("fma_ctrl", {28'b0, fma_mul, fma_add, fma_negr, fma_negz}, {28'b0, ref_ctrl(t.op)});
            chk("fma_xyz", {fma_x, fma_y ^ fma_z}, {t.x, t.y ^ t.z});
            chk("fma_rm", {30'b0, fma_rm}, {30'b0, t.rm});
            if (gap_chk && last_hs >= 0) chk("throughput_gap", cyc - last_hs, 2);
            last_hs = cyc;
        end
        if (acc) begin
            t.op = in_op; t.x = in_x; t.y = in_y; t.z = in_z; t.rm = in_rm; t.cst = stub_const;
            exp_q.push_back(t);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_op(input logic [2:0] op);
        in_op = op;
        in_x  = 16'($urandom);
        in_y  = 16'($urandom);
        in_z  = 16'($urandom);
        in_rm = 2'($urandom);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drain until the model queue is empty and the DUT idle, with a cycle budget.
    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_drain_empty"}, exp_q.size(), 0);
        chk({tag, "_drain_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        reset = 1'b1;
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_result", {16'b0, out_result}, 0);
        chk("rst_out_err", {31'b0, out_err}, 0);
        chk("rst_fma_ports", {fma_x, fma_y | fma_z}, 0);
        chk("rst_fma_ctrl", {26'b0, fma_rm, fma_mul, fma_add, fma_negr, fma_negz}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_busy", {31'b0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // fmadd issue with constant stub and 2-cycle latency
        stub_const = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 3'd3; in_x = 16'h3C00; in_y = 16'h4000; in_z = 16'h3C00; in_rm = 2'b01;
        step();
        in_valid = 1'b0;
        chk("lat_n1_out_valid", {31'b0, out_valid}, 0);
        step();
        chk("exec_fma_x", {16'b0, fma_x}, 32'h3C00);
        chk("exec_fma_y", {16'b0, fma_y}, 32'h4000);
        chk("exec_fma_z", {16'b0, fma_z}, 32'h3C00);
        chk("exec_ctrl", {28'b0, fma_mul, fma_add, fma_negr, fma_negz}, 32'b1100);
        chk("exec_rm", {30'b0, fma_rm}, 1);
        chk("lat_n2_pre", {31'b0, out_valid}, 0);
        step();
        chk("lat_out_valid", {31'b0, out_valid}, 1);
        chk("lat_out_result", {16'b0, out_result}, 32'h4200);
        step();
        step();
        chk("hold_out_valid", {31'b0, out_valid}, 1);
        drain("fmadd");
        stub_const = 1'b0;

        // Decode sweep 0..7, then a legal op after the illegal one
        out_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            set_op(3'(op));
            in_valid = 1'b1;
            step();
        end
        set_op(3'd0);
        step();
        drain("sweep");

        // Full and backpressure: 1 in DONE + 4 in FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("full_in_ready_pre", {31'b0, in_ready}, 1);
            set_op(3'($urandom_range(0, 6)));
            in_valid = 1'b1;
            step();
        end
        chk("full_in_ready_low", {31'b0, in_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            set_op(3'd2);
            step();
        end
        chk("full_still_low", {31'b0, in_ready}, 0);
        in_valid = 1'b0;
        gap_chk = 1'b1;
        last_hs = -1;
        drain("full");
        gap_chk = 1'b0;

        // Simultaneous push and pop with count 2
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(3'($urandom_range(0, 7)));
            in_valid = 1'b1;
            step();
        end
        chk("pp_done_valid", {31'b0, out_valid}, 1);
        set_op(3'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        set_op(3'd4);
        chk("pp_ready_a", {31'b0, in_ready}, 1);
        step();
        set_op(3'd5);
        chk("pp_ready_b", {31'b0, in_ready}, 1);
        step();
        chk("pp_full_after2", {31'b0, in_ready}, 0);
        drain("pp");

        // Reset during EXEC
        set_op(3'd3);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("rst_exec_out_valid", {31'b0, out_valid}, 0);
        chk("rst_exec_busy", {31'b0, busy}, 0);
        chk("rst_exec_in_ready", {31'b0, in_ready}, 1);
        chk("rst_exec_fma_x", {16'b0, fma_x}, 0);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("rst_exec_no_stale", {31'b0, out_valid | busy}, 0);

        // Reset during DONE
        set_op(3'd6);
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("pre_rst_done_valid", {31'b0, out_valid}, 1);
        reset = 1'b1;
        #1;
        chk("rst_done_out_valid", {31'b0, out_valid}, 0);
        chk("rst_done_out_result", {16'b0, out_result}, 0);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("rst_done_no_stale", {31'b0, out_valid | busy}, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            set_op(3'($urandom));
            step();
        end
        drain("rand");

`ifdef FMA16_ISSUE_PERF_EN
        // Performance counters
        do_reset();
        chk("perf_rst_ops", {16'b0, perf_ops}, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(3'd0);
            in_valid = 1'b1;
            step();
        end
        drain("perf");
        chk("perf_ops", {16'b0, perf_ops}, 3);
        chk("perf_stall_zero", {16'b0, perf_stall}, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(3'd2);
            in_valid = 1'b1;
            step();
        end
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        chk("perf_stall", {16'b0, perf_stall}, 4);
        drain("perf2");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fma16_issue.md
# fma16_issue

Operand issue and result-capture stage placed directly upstream of the combinational `fma16` datapath. It accepts opcode-tagged operand triples over a valid/ready handshake and buffers them in a small FIFO. Each operation is decoded into the `mul/add/negr/negz` controls, the operands are held stable on the `fma16` input ports for one full cycle, and the `fma16` result is registered onto an output valid/ready channel. This stage gives the purely combinational FPU a flow-controlled, registered boundary to the rest of the design.

## Interface
- `DEPTH`, 4, input FIFO entries; power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  `!fifo_full`.
- `in_op`  in  3  opcode: 000 fadd, 001 fsub, 010 fmul, 011 fmadd, 100 fmsub, 101 fnmadd, 110 fnmsub, 111 illegal.
- `in_x`, `in_y`, `in_z`  in  16 each  binary16 operands.
- `in_rm`  in  2  rounding mode: 00 rz, 01 rne, 10 rp, 11 rn.
- `fma_x`, `fma_y`, `fma_z`  out  16 each  operands driven to `fma16`.
- `fma_mul`, `fma_add`, `fma_negr`, `fma_negz`  out  1 each  decoded controls.
- `fma_rm`  out  2  rounding mode driven to `fma16`.
- `fma_result`  in  16  combinational result from `fma16`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_result`  out  16  registered result.
- `out_err`  out  1  the completed op carried the illegal opcode.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- **FIFO.** Stores `{op, x, y, z, rm}`. Push occurs when `in_valid && in_ready`. Pointers wrap modulo `DEPTH`. A separate count register distinguishes full from empty.
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE.**
  - If the FIFO is non-empty: pop the head into the op register and go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC.**
  - The op register drives the `fma_*` ports for exactly this cycle.
  - At the closing edge, capture `fma_result` into `out_result` and set `out_valid=1`. Then go to DONE.
- **DONE.**
  - Hold `out_valid`, `out_result` and `out_err` stable until `out_valid && out_ready`.
  - On that handshake edge: if the FIFO is non-empty, pop into the op register and go to EXEC. Otherwise go to IDLE. In both cases clear `out_valid`.
- **Opcode decode** to `{mul, add, negr, negz}`:
  - fadd 0100
  - fsub 0101
  - fmul 1000
  - fmadd 1100
  - fmsub 1101
  - fnmadd 1110
  - fnmsub 1111
- **Illegal opcode (111).**
  - Controls are driven as 0000.
  - `out_result` is forced to 16'h7E00 (canonical NaN); `fma_result` is ignored.
  - `out_err=1` for that result only.
- **FIFO full.** `in_ready=0` even if a pop occurs in the same cycle; there is no fall-through.
- **Push and pop in the same cycle** (FIFO not full): both occur and the count is unchanged.
- **Push into an empty FIFO while in IDLE.** The entry is written on edge N and popped on edge N+1; there is no bypass.
- **Ports while not in EXEC.** `fma_*` ports hold the last issued operands and controls. Downstream must use only the EXEC-cycle value.
- **Reset (asserted at any time, including mid-EXEC or DONE).**
  - FSM goes to IDLE; FIFO is emptied; the in-flight op is dropped.
  - `out_valid=0`, `out_result=0`, `out_err=0`, all `fma_*` outputs 0.
  - `in_ready=1`, `busy=0`.

## Timing
- Push accepted at edge N into an empty FIFO in IDLE:
  - EXEC during cycle N+1 → N+2.
  - `out_valid=1` after edge N+2. Latency is 2 cycles from the accepting edge to visible `out_valid`.
- Back-to-back throughput with `out_ready` held high: one result every 2 cycles (EXEC, DONE alternate).
- `fma16` combinational path budget: from the op-register Q outputs to the `out_result` D inputs, one full cycle.
- `in_ready` depends only on count; it is registered-derived with no combinational path from `out_ready`.
- `out_valid`, `out_result` and `out_err` are direct register outputs.

## Configuration
- **`FMA16_ISSUE_PERF_EN` defined:**
  - Adds output `perf_ops[15:0]`, which increments on every output handshake and wraps from 16'hFFFF to 0.
  - Adds output `perf_stall[15:0]`, which increments each cycle `in_valid && !in_ready` and saturates at 16'hFFFF.
  - Both counters reset to 0.
- **`FMA16_ISSUE_PERF_EN` undefined:** both ports and counters are absent; all other behaviour is identical.

## Test plan
- **fmadd issue.** fmadd with x=3C00, y=4000, z=3C00, rm=01 → in the EXEC cycle `fma_x/y/z` match, controls=1100, `fma_rm`=01. With a stub returning 4200, `out_result`=4200 two cycles after push.
- **Decode sweep.** Each opcode 000–110 → `{mul, add, negr, negz}` matches the decode list. Opcode 111 → `out_result`=7E00, `out_err`=1, next op `out_err`=0.
- **Full and backpressure.** Hold `out_ready=0` and push DEPTH+1=5 ops → `in_ready` drops after the 5th accept (1 in DONE, 4 in FIFO). Releasing `out_ready` drains the results in order at 1 per 2 cycles.
- **Simultaneous push and pop.** Push while DONE hands off with count 2 → count stays 2, order preserved, no loss or duplication.
- **Reset mid-operation.** Assert reset during EXEC and during DONE → `out_valid` is 0 immediately (async). After release, `busy`=0, `in_ready`=1, and no stale result emerges.
- **Perf counters (`FMA16_ISSUE_PERF_EN`).** After 3 completed ops → `perf_ops`=3. 4 stall cycles while full → `perf_stall`=4.
